// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential binary neural network block.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed accumulator width that holds +/- FEAT_CNT * (2^FEAT_BITS - 1).
    function automatic int sum_width(input int feat_cnt, input int feat_bits);
        return feat_bits + $clog2(feat_cnt) + 1;
    endfunction

    // Width of an index over n items, never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a popcount over hidden_cnt bits (0..hidden_cnt inclusive).
    function automatic int score_width(input int hidden_cnt);
        return $clog2(hidden_cnt + 1);
    endfunction

endpackage

// File: rtl/bnn_hidden_neuron.sv
// One binary hidden neuron: signed sum of +/- features, fires when the sum is non-negative.
module bnn_hidden_neuron
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT  = 11,
    parameter int FEAT_BITS = 4
) (
    input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [FEAT_CNT-1:0]           weights,
    output logic                          fire
);

    localparam int SumW = sum_width(FEAT_CNT, FEAT_BITS);

    logic signed [SumW-1:0] sum;
    logic signed [SumW-1:0] x;

    // Accumulate +x_f for a 1 weight and -x_f for a 0 weight.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred;
        // blocking assignments are right here because each step feeds the next.
        sum = '0;
        x   = '0;
        for (int f = 0; f < FEAT_CNT; f++) begin
            x = SumW'(features[f*FEAT_BITS +: FEAT_BITS]);
            if (weights[f]) begin
                sum = sum + x;
            end else begin
                sum = sum - x;
            end
        end
    end

    assign fire = !sum[SumW-1];

endmodule

// File: rtl/bnn_seq_stream.sv
// Sequential BNN: hidden layer PAR neurons per cycle, then one class per cycle with a running argmax.
module bnn_seq_stream
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT   = 11,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int PAR        = 4,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  Weights0 = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]         features,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [index_width(CLASS_CNT)-1:0]     prediction,
    output logic [score_width(HIDDEN_CNT)-1:0]    score
);

    localparam int Groups = (HIDDEN_CNT + PAR - 1) / PAR;
    localparam int GrpW   = index_width(Groups);
    localparam int ClsW   = index_width(CLASS_CNT);
    localparam int ScoreW = score_width(HIDDEN_CNT);

    state_t                        state;
    logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
    logic [HIDDEN_CNT-1:0]         hidden_q;
    logic [HIDDEN_CNT-1:0]         hidden_next;
    logic [GrpW-1:0]               grp;
    logic [ClsW-1:0]               cls;
    logic [ScoreW-1:0]             best_score;
    logic [ClsW-1:0]               best_idx;
    logic [PAR-1:0]                fire;

    logic [HIDDEN_CNT-1:0]         w1_row;
    logic [HIDDEN_CNT-1:0]         agree;
    logic [ScoreW-1:0]             cls_score;
    logic                          take_new;
    logic [ClsW-1:0]               win_idx;
    logic [ScoreW-1:0]             win_score;

    assign in_ready = (state == IDLE);

    // One neuron lane per PAR slot; lane p handles neuron grp*PAR+p of the current group.
    for (genvar p = 0; p < PAR; p++) begin : g_lane
        int                  idx;
        int                  idx_c;
        logic [FEAT_CNT-1:0] row;

        assign idx   = int'(grp) * PAR + p;
        // Lanes past the last neuron read row 0; their result is never stored.
        assign idx_c = (idx < HIDDEN_CNT) ? idx : 0;
        assign row   = Weights0[idx_c*FEAT_CNT +: FEAT_CNT];

        bnn_hidden_neuron #(
            .FEAT_CNT  (FEAT_CNT),
            .FEAT_BITS (FEAT_BITS)
        ) u_neuron (
            .features (feat_q),
            .weights  (row),
            .fire     (fire[p])
        );
    end

    // Merge this group's lane outputs into the hidden vector; out-of-range lanes match no bit.
    always_comb begin
        hidden_next = hidden_q;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            for (int p = 0; p < PAR; p++) begin
                if (int'(grp) * PAR + p == h) begin
                    hidden_next[h] = fire[p];
                end
            end
        end
    end

    assign w1_row = Weights1[int'(cls)*HIDDEN_CNT +: HIDDEN_CNT];
    assign agree  = ~(w1_row ^ hidden_q);

    // Popcount of agreeing bits between the class weight row and the hidden vector.
    always_comb begin
        cls_score = '0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            cls_score = cls_score + ScoreW'(agree[h]);
        end
    end

    // Class 0 seeds the argmax; later classes win only on a strictly greater score.
    assign take_new  = (cls == '0) || (cls_score > best_score);
    assign win_idx   = take_new ? cls : best_idx;
    assign win_score = take_new ? cls_score : best_score;

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the hidden vector is a plain register bank, so it is cleared with
            // everything else; there is no memory macro here that would forbid a reset.
            state      <= IDLE;
            feat_q     <= '0;
            hidden_q   <= '0;
            grp        <= '0;
            cls        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            out_valid  <= 1'b0;
            prediction <= '0;
            score      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q <= features;
                        grp    <= '0;
                        state  <= L0;
                    end
                end
                L0: begin
                    hidden_q <= hidden_next;
                    if (grp == GrpW'(Groups - 1)) begin
                        grp   <= '0;
                        cls   <= '0;
                        state <= L1;
                    end else begin
                        grp <= grp + GrpW'(1);
                    end
                end
                L1: begin
                    best_idx   <= win_idx;
                    best_score <= win_score;
                    if (cls == ClsW'(CLASS_CNT - 1)) begin
                        prediction <= win_idx;
                        score      <= win_score;
                        out_valid  <= 1'b1;
                        cls        <= '0;
                        state      <= DONE;
                    end else begin
                        cls <= cls + ClsW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_stream.sv
// Bench: four weight sets, each at PAR=2 and PAR=3, driven in lockstep against a behavioural model.
module tb_bnn_seq_stream;

    localparam int FC = 2;
    localparam int FB = 4;
    localparam int HC = 4;
    localparam int CC = 3;
    localparam int NCFG = 4;
    localparam int NDUT = 2 * NCFG;
    // Accepting edge is cycle 1 of the sample; the result appears in cycle LAT.
    localparam int LAT = 2 + CC + 1;

    // Config 0: W0 all 1, W1 row1 only.  1: W0 all 1, W1 zero.
    // Config 2: W0 zero, W1 rows 0/1 all 1, row2 zero.  3: mixed weights.
    localparam logic [NCFG*8-1:0]  W0_ALL = {8'b1011_0110, 8'h00, 8'hFF, 8'hFF};
    localparam logic [NCFG*12-1:0] W1_ALL = {12'b1010_0110_1101, 12'b0000_1111_1111,
                                             12'h000, 12'b0000_1111_0000};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   features = '0;
    logic         out_ready = 1'b1;

    logic         in_ready_v  [NDUT];
    logic         out_valid_v [NDUT];
    logic [1:0]   pred_v      [NDUT];
    logic [2:0]   score_v     [NDUT];

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        bnn_seq_stream #(
            .FEAT_CNT   (FC),
            .FEAT_BITS  (FB),
            .HIDDEN_CNT (HC),
            .CLASS_CNT  (CC),
            .PAR        ((k % 2) ? 3 : 2),
            .Weights0   (W0_ALL[(k/2)*8 +: 8]),
            .Weights1   (W1_ALL[(k/2)*12 +: 12])
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready_v[k]),
            .features   (features),
            .out_valid  (out_valid_v[k]),
            .out_ready  (out_ready),
            .prediction (pred_v[k]),
            .score      (score_v[k])
        );
    end

    task automatic check(input string name, input int k, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference network: plain integer arithmetic straight from the layer definitions.
    function automatic void model(input int cfg, input int f0, input int f1,
                                  output int pred, output int sc);
        logic [7:0]  w0;
        logic [11:0] w1;
        int hb [HC];
        int s, cnt, best;
        w0 = W0_ALL[cfg*8 +: 8];
        w1 = W1_ALL[cfg*12 +: 12];
        for (int h = 0; h < HC; h++) begin
            s = (w0[h*FC] ? f0 : -f0) + (w0[h*FC+1] ? f1 : -f1);
            hb[h] = (s >= 0) ? 1 : 0;
        end
        best = -1;
        pred = 0;
        for (int c = 0; c < CC; c++) begin
            cnt = 0;
            for (int h = 0; h < HC; h++) begin
                if (int'(w1[c*HC+h]) == hb[h]) cnt++;
            end
            if (cnt > best) begin
                best = cnt;
                pred = c;
            end
        end
        sc = best;
    endfunction

    // Transaction-level expectation: busy from acceptance, valid LAT-1 edges later, held until taken.
    bit exp_busy = 1'b0;
    bit exp_valid = 1'b0;
    int edge_cnt = 0;
    int lat_f0 = 0;
    int lat_f1 = 0;
    int exp_pred  [NCFG] = '{default: 0};
    int exp_score [NCFG] = '{default: 0};
    int mp, ms;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_busy  <= 1'b0;
            exp_valid <= 1'b0;
            edge_cnt  <= 0;
            for (int c = 0; c < NCFG; c++) begin
                exp_pred[c]  <= 0;
                exp_score[c] <= 0;
            end
        end else if (exp_valid) begin
            if (out_ready) begin
                exp_valid <= 1'b0;
                exp_busy  <= 1'b0;
            end
        end else if (exp_busy) begin
            edge_cnt <= edge_cnt + 1;
            if (edge_cnt + 1 == LAT - 1) begin
                exp_valid <= 1'b1;
                for (int c = 0; c < NCFG; c++) begin
                    model(c, lat_f0, lat_f1, mp, ms);
                    exp_pred[c]  <= mp;
                    exp_score[c] <= ms;
                end
            end
        end else if (in_valid) begin
            exp_busy <= 1'b1;
            edge_cnt <= 0;
            lat_f0   <= int'(features[3:0]);
            lat_f1   <= int'(features[7:4]);
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NDUT; k++) begin
                check("in_ready",   k, int'(in_ready_v[k]),  int'(!exp_busy));
                check("out_valid",  k, int'(out_valid_v[k]), int'(exp_valid));
                check("prediction", k, int'(pred_v[k]),      exp_pred[k/2]);
                check("score",      k, int'(score_v[k]),     exp_score[k/2]);
            end
        end
    end

    // Present one sample from IDLE and measure when the result first shows.
    task automatic send(input int f0, input int f1);
        int  n;
        bit  seen;
        @(negedge clk);
        in_valid = 1'b1;
        features = {4'(f1), 4'(f0)};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        features = 8'($urandom);
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                n++;
                if (out_valid_v[0]) seen = 1'b1;
            end
        end
        check("latency", 0, n, LAT);
        check("latency_par3", 1, int'(out_valid_v[1]), 1);
    endtask

    task automatic expect_lit(input int k, input int p, input int s);
        check("lit_prediction", k, int'(pred_v[k]), p);
        check("lit_score",      k, int'(score_v[k]), s);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                @(negedge clk);
                if (in_ready_v[0]) done = 1'b1;
            end
        end
        check("return_idle", 0, int'(done), 1);
    endtask

    initial begin
        int p, s;

        // Pin the reference model to hand-derived results.
        model(0, 3, 5, p, s); check("model_pin_p", 0, p, 1); check("model_pin_s", 0, s, 4);
        model(1, 3, 5, p, s); check("model_pin_p", 1, p, 0); check("model_pin_s", 1, s, 0);
        model(2, 1, 0, p, s); check("model_pin_p", 2, p, 2); check("model_pin_s", 2, s, 4);
        model(2, 0, 0, p, s); check("model_pin_p", 2, p, 0); check("model_pin_s", 2, s, 4);

        #2 rst = 1'b0;
        @(negedge clk);
        checking = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            check("reset_in_ready", k, int'(in_ready_v[k]), 1);
            check("reset_out_valid", k, int'(out_valid_v[k]), 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Directed samples with literal expectations for the first three configs.
        out_ready = 1'b1;
        send(3, 5);
        for (int q = 0; q < 2; q++) begin
            expect_lit(q, 1, 4); expect_lit(2 + q, 0, 0); expect_lit(4 + q, 2, 4);
        end
        wait_idle();
        send(0, 0);
        for (int q = 0; q < 2; q++) begin
            expect_lit(q, 1, 4); expect_lit(2 + q, 0, 0); expect_lit(4 + q, 0, 4);
        end
        wait_idle();
        send(1, 0);
        for (int q = 0; q < 2; q++) begin
            expect_lit(q, 1, 4); expect_lit(2 + q, 0, 0); expect_lit(4 + q, 2, 4);
        end
        wait_idle();

        // Backpressure: hold the result for 10 cycles with in_valid noise.
        out_ready = 1'b0;
        send(5, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            features = 8'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 0, int'(out_valid_v[0]), 0);
        check("release_ready", 0, int'(in_ready_v[0]), 1);

        // Reset during the second class-evaluation cycle discards the sample.
        @(negedge clk);
        in_valid = 1'b1;
        features = {4'd7, 4'd2};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            check("midrst_valid", k, int'(out_valid_v[k]), 0);
            check("midrst_ready", k, int'(in_ready_v[k]), 1);
        end
        repeat (2) @(negedge clk);
        send(1, 0);
        expect_lit(0, 1, 4); expect_lit(4, 2, 4); expect_lit(5, 2, 4);
        wait_idle();

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            features  = 8'($urandom);
            out_ready = (($urandom % 4) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        checking = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bnn_seq_stream.md
BNN_SEQ_STREAM -- requirements
Module: bnn_seq_stream

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 11, number of input features.
REQ-002 SHALL have parameter FEAT_BITS, default 4, unsigned bits per feature.
REQ-003 SHALL have parameter HIDDEN_CNT, default 40, hidden binary neurons.
REQ-004 SHALL have parameter CLASS_CNT, default 6, output classes.
REQ-005 SHALL have parameter PAR, default 4, hidden neurons evaluated per cycle; legal range 1..HIDDEN_CNT.
REQ-006 SHALL have parameter Weights0, default all-zero, HIDDEN_CNT*FEAT_CNT bits; bit h*FEAT_CNT+f is the weight from feature f to neuron h.
REQ-007 SHALL have parameter Weights1, default all-zero, CLASS_CNT*HIDDEN_CNT bits; bit c*HIDDEN_CNT+h is the weight from neuron h to class c.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst  input  1  asynchronous active-low reset.
REQ-010 in_valid  input  1  features valid.
REQ-011 in_ready  output  1  block can accept a sample.
REQ-012 features  input  FEAT_CNT*FEAT_BITS  feature f at bits [f*FEAT_BITS +: FEAT_BITS].
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 prediction  output  $clog2(CLASS_CNT)  winning class index.
REQ-016 score  output  $clog2(HIDDEN_CNT+1)  winning class popcount.

Function
REQ-017 FSM states SHALL be IDLE, L0, L1, DONE; in_ready SHALL equal (state==IDLE).
REQ-018 On in_valid&&in_ready, features SHALL be registered and state SHALL go IDLE->L0; group counter SHALL be cleared.
REQ-019 Hidden neuron h SHALL compute signed S_h = sum over f of (w ? +x_f : -x_f), width FEAT_BITS+$clog2(FEAT_CNT)+1; bit h_b = (S_h >= 0).
REQ-020 In L0, neurons g*PAR..g*PAR+PAR-1 SHALL be evaluated in cycle g; indices >= HIDDEN_CNT SHALL be masked; L0 SHALL last ceil(HIDDEN_CNT/PAR) cycles, then go to L1.
REQ-021 In L1, one class per cycle in ascending order: score_c = popcount(XNOR(Weights1 row c, hidden bits)); L1 SHALL last CLASS_CNT cycles, then go to DONE.
REQ-022 Running argmax SHALL replace the best only on strictly greater score, so ties resolve to the lowest class index.
REQ-023 In DONE, out_valid SHALL be 1 and prediction/score SHALL be stable; on out_ready, state SHALL go to IDLE and out_valid SHALL drop next cycle.
REQ-024 Latency from the accepting edge to the first out_valid cycle SHALL be ceil(HIDDEN_CNT/PAR)+CLASS_CNT+1 cycles; throughput one sample per latency+1 cycles with out_ready held high.
REQ-025 in_valid outside IDLE SHALL be ignored; features changing after acceptance SHALL not affect the result.
REQ-026 prediction and score SHALL hold the last result after DONE exits, until the next DONE.

Reset
REQ-027 rst low SHALL force state IDLE, out_valid 0, prediction 0, score 0, hidden register 0, counters 0, independent of clk.
REQ-028 in_ready SHALL read 1 during and after reset; reset mid-L0/L1/DONE SHALL discard the sample with no out_valid.

Structure
REQ-029 Package bnn_pkg SHALL hold the state enum and width helper functions (sum width, index width, score width).
REQ-030 Sub-module bnn_hidden_neuron (combinational signed sum and threshold for one neuron) SHALL be instantiated PAR times; weight-row selection SHALL stay in bnn_seq_stream.

Verification (FEAT_CNT=2, FEAT_BITS=4, HIDDEN_CNT=4, CLASS_CNT=3, PAR=2)
REQ-031 Weights0 all 1, Weights1 row1=4'b1111 and others 0, features {3,5} -> prediction 1, score 4, out_valid high exactly 6 cycles after the accepting edge.
REQ-032 Weights1 all 0, Weights0 all 1 -> all scores 0, tie -> prediction 0, score 0.
REQ-033 Weights0 all 0, features {0,0} -> S_h=0, all hidden bits 1; features {1,0} -> all hidden bits 0; with Weights1 row2=4'b0000, others 4'b1111, second case -> prediction 2, score 4.
REQ-034 out_ready held low 10 cycles in DONE -> out_valid and outputs stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-035 rst asserted in cycle 2 of L1 -> out_valid stays 0, in_ready 1; the next sample completes with the correct result and nominal latency.
REQ-036 PAR=3 (non-dividing) -> L0 takes 2 cycles, latency 6, results identical to the PAR=2 runs.
